// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_driver: ap_ctrl_chain initiator that runs batches of kernel
// transactions, keeps at most MAX_OUT of them outstanding and counts
// issues, completions and busy cycles.
// Optional feature: define AP_CTRL_DRIVER_LAT_STATS_EN to add per-transaction
// start-to-done latency tracking (lat_min / lat_max ports).
module ap_ctrl_driver #(
  parameter int CNT_W   = 32,
  parameter int MAX_OUT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [15:0]      cmd_num,
  output logic             cmd_ready,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  input  logic             stall,
  output logic             busy,
  output logic             batch_done,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] cycle_cnt
`ifdef AP_CTRL_DRIVER_LAT_STATS_EN
  ,
  output logic [CNT_W-1:0] lat_min,
  output logic [CNT_W-1:0] lat_max
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] OUT_LIM = CNT_W'(MAX_OUT);

  logic [1:0]       rst_sync_r;
  logic             rst_n_s;
  state_t           state_r, state_n_s;
  logic [15:0]      num_r, num_n_s;
  logic [CNT_W-1:0] issued_r, issued_n_s;
  logic [CNT_W-1:0] done_r, done_n_s;
  logic [CNT_W-1:0] cycle_r, cycle_n_s;
  logic [CNT_W-1:0] outstanding_s;
  logic             ap_start_r, ap_start_n_s;
  logic             busy_r, busy_n_s;
  logic             batch_done_r;
  logic             run_s, cont_s, issue_s, cmpl_s, accept_s;

  // Two-flop synchroniser: assertion is immediate, release is clocked.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s       = rst_sync_r[1];
  assign run_s         = (state_r == RUN) || (state_r == DRAIN);
  assign cont_s        = run_s && !stall;
  assign outstanding_s = issued_r - done_r;
  assign issue_s       = ap_start_r && ap_ready;
  // A done with nothing outstanding is spurious and never counted.
  assign cmpl_s        = ap_done && cont_s && (outstanding_s != {CNT_W{1'b0}});

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_n_s  = state_r;
    num_n_s    = num_r;
    accept_s   = 1'b0;
    issued_n_s = issue_s ? (issued_r + CNT_W'(1)) : issued_r;
    done_n_s   = cmpl_s ? (done_r + CNT_W'(1)) : done_r;
    cycle_n_s  = (run_s && (cycle_r != CNT_MAX)) ? (cycle_r + CNT_W'(1)) : cycle_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          accept_s   = 1'b1;
          num_n_s    = cmd_num;
          issued_n_s = {CNT_W{1'b0}};
          done_n_s   = {CNT_W{1'b0}};
          cycle_n_s  = {CNT_W{1'b0}};
          state_n_s  = (cmd_num == 16'd0) ? FIN : RUN;
        end else begin
          state_n_s = IDLE;
        end
      end
      RUN: begin
        if (issued_r == CNT_W'(num_r)) begin
          state_n_s = DRAIN;
        end else begin
          state_n_s = RUN;
        end
      end
      DRAIN: begin
        if (done_r == CNT_W'(num_r)) begin
          state_n_s = FIN;
        end else begin
          state_n_s = DRAIN;
        end
      end
      FIN:     state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
    // Start is computed from next-cycle counters so the registered copy
    // behaves exactly like a decode of the current ones.
    ap_start_n_s = (state_n_s == RUN) &&
                   (issued_n_s < CNT_W'(num_n_s)) &&
                   ((issued_n_s - done_n_s) < OUT_LIM);
    busy_n_s     = (state_n_s == RUN) || (state_n_s == DRAIN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r      <= IDLE;
      num_r        <= 16'd0;
      issued_r     <= {CNT_W{1'b0}};
      done_r       <= {CNT_W{1'b0}};
      cycle_r      <= {CNT_W{1'b0}};
      ap_start_r   <= 1'b0;
      busy_r       <= 1'b0;
      batch_done_r <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      num_r        <= num_n_s;
      issued_r     <= issued_n_s;
      done_r       <= done_n_s;
      cycle_r      <= cycle_n_s;
      ap_start_r   <= ap_start_n_s;
      busy_r       <= busy_n_s;
      batch_done_r <= (state_r == FIN);
    end
  end

  assign cmd_ready   = (state_r == IDLE) && rst_n_s;
  assign ap_start    = ap_start_r;
  assign ap_continue = cont_s;
  assign busy        = busy_r;
  assign batch_done  = batch_done_r;
  assign issued_cnt  = issued_r;
  assign done_cnt    = done_r;
  assign cycle_cnt   = cycle_r;

`ifdef AP_CTRL_DRIVER_LAT_STATS_EN
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);

  logic [CNT_W-1:0] ts_mem_r [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] lat_min_r, lat_max_r;
  logic [CNT_W-1:0] lat_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : (p + PTR_W'(1));
  endfunction

  // Completions are in issue order, so the oldest timestamp belongs to them.
  assign lat_s = cycle_r - ts_mem_r[rd_ptr_r] + CNT_W'(1);

  // Timestamp ring buffer and latency extremes.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        ts_mem_r[i] <= {CNT_W{1'b0}};
      end
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      lat_min_r <= CNT_MAX;
      lat_max_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      lat_min_r <= CNT_MAX;
      lat_max_r <= {CNT_W{1'b0}};
    end else begin
      if (issue_s) begin
        ts_mem_r[wr_ptr_r] <= cycle_r;
        wr_ptr_r           <= ptr_inc(wr_ptr_r);
      end
      if (cmpl_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
        if (lat_s < lat_min_r) lat_min_r <= lat_s;
        if (lat_s > lat_max_r) lat_max_r <= lat_s;
      end
    end
  end

  assign lat_min = lat_min_r;
  assign lat_max = lat_max_r;
`endif

endmodule
